cell_row_loader: RTL
====================

Name: cell_row_loader

Overview:
- Avalon-MM slave front end that loads the per-cell 4-bit LUT configuration of one logic-cell row.
- Sits directly upstream of the cell row. Drives its we_ram and set_ram inputs slot by slot from a stream of PORT_WIDTH-bit host writes.
- Owns the slot pointer, write-enable strobe timing, completion/error status and waitrequest back-pressure.

Parameters:
- DIMX, 64: cells per row.
- PORT_WIDTH, 32: Avalon data width in bits. DIMX*4 must be a multiple of PORT_WIDTH.
- SLOTS, DIMX*4/PORT_WIDTH: write slots per row. Slot k covers set_ram[k*PORT_WIDTH +: PORT_WIDTH].
- PTR_W, clog2(SLOTS) (min 1): slot pointer width.

Ports:
- clk  in  1  FPGA clock
- rst  in  1  reset; synchronous, active-high
- avs_address  in  2  register select: 0 CTRL, 1 STATUS, 2 DATA, 3 reserved
- avs_write  in  1  write request
- avs_writedata  in  PORT_WIDTH  write data
- avs_read  in  1  read request
- avs_readdata  out  PORT_WIDTH  read data, registered
- avs_waitrequest  out  1  stall; master holds its request while high
- we_ram  out  SLOTS  RAM write enable to the row, one-hot pulse
- set_ram  out  DIMX*4  RAM set data to the row, held between loads
- busy  out  1  load in progress
- done  out  1  sticky, all SLOTS slots written

Behaviour:
- Reset: on rst high at a clk edge, all of the following are 0:
  - we_ram, set_ram, avs_readdata, avs_waitrequest, busy, done
  - ptr, err
  - FSM goes to IDLE.
- rst mid-load aborts the load. No we_ram pulse is issued in the cycle after reset.
- FSM states: IDLE, LOAD, STROBE. busy = (state != IDLE).
- CTRL write, bit0 = START (accepted in any state, even STROBE):
  - Sets ptr=0, done=0, err=0; next state LOAD.
  - If issued in STROBE, the pending strobe still completes that cycle, then the state becomes LOAD with ptr=0.
- CTRL write, bit1 = CLR: clears done and err; state unchanged. Bit0 has priority if both bits are set.
- DATA write in LOAD, accepted at edge N:
  - set_ram[ptr*PORT_WIDTH +: PORT_WIDTH] <= avs_writedata; state -> STROBE.
  - Other slots are unchanged.
- STROBE (cycle N+1):
  - we_ram = 1<<ptr, registered, exactly one cycle wide.
  - avs_waitrequest = 1, combinational from state == STROBE.
  - At the end of the cycle: if ptr == SLOTS-1, set done=1, ptr=0, state -> IDLE. Otherwise ptr++ and state -> LOAD.
- Throughput: one DATA word per 2 cycles. A full row takes 2*SLOTS cycles after START.
- DATA write in IDLE: data dropped, err=1 (sticky), no we_ram pulse, no stall.
- Writes to address 3 are ignored. Reads of address 3 return 0.
- Reads:
  - Never stalled; read latency 1; avs_readdata registered.
  - Address 0 returns 0.
  - Address 1 returns STATUS = {zero-pad, ptr[PTR_W-1:0] at bits [8+:PTR_W], err at bit2, done at bit1, busy at bit0}.
  - Address 2 returns the current slot word, set_ram[ptr*PORT_WIDTH +: PORT_WIDTH].
- Simultaneous avs_read and avs_write: the write is performed and the read is ignored; avs_readdata holds its previous value.
- we_ram only ever asserts in STROBE. At most one bit is set in any cycle.
- set_ram is stable in every cycle where its slot's we_ram bit is high.

Test Plan:
- Reset: drive rst 3 cycles with random bus activity -> all outputs 0; STATUS read returns 0x0.
- Full load, DIMX=64, SLOTS=8: START, then 8 DATA writes of 0x1111_1111*k for k=1..8 -> we_ram pulses 0x01,0x02,...,0x80 one cycle each, 2 cycles apart; final set_ram slot k-1 = 0x1111_1111*k; done=1, busy=0; STATUS = 0x0000_0002.
- Back-pressure: master asserts DATA write continuously -> waitrequest high exactly on STROBE cycles; no slot written twice; ptr visible in STATUS[10:8] increments 0..7.
- Error path: DATA write 0xDEAD_BEEF in IDLE after reset -> set_ram unchanged (0), we_ram never asserts, STATUS = 0x0000_0004. A CLR write then gives STATUS = 0x0.
- Restart: START, 3 DATA writes, START again, 8 writes -> slots 0..2 hold the second-pass data; no we_ram pulse is lost or duplicated at the restart.
- Mid-load reset: assert rst during STROBE of slot 4 -> the next cycle shows we_ram=0, set_ram=0, busy=0, done=0.

Source files
------------

// File: rtl/cell_row_loader.sv
// cell_row_loader
//   Avalon-MM slave that loads the 4-bit LUT configuration of one logic-cell
//   row. The host writes START, then SLOTS words to DATA. Each word is placed
//   into its slot of set_ram and followed by a one-cycle we_ram strobe for
//   that slot.
//
// Register map (avs_address):
//   0 CTRL   write: bit0 START (restart the load at slot 0), bit1 CLR (clear done/err)
//            read : 0
//   1 STATUS read : {ptr at [8+:PTR_W], err[2], done[1], busy[0]}
//   2 DATA   write: next slot word; read: word at the current slot pointer
//   3 reserved (writes ignored, reads 0)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   avs_*             Avalon-MM slave; readdata is registered, latency 1
//   avs_waitrequest   high during the strobe cycle only
//   we_ram            one-hot per-slot write enable to the row
//   set_ram           row set data, held between loads
//   busy, done        load in progress / all slots written (sticky)
module cell_row_loader #(
   parameter int DIMX       = 64,
   parameter int PORT_WIDTH = 32,
   parameter int SLOTS      = DIMX * 4 / PORT_WIDTH,
   parameter int PTR_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            avs_address,
   input  logic                  avs_write,
   input  logic [PORT_WIDTH-1:0] avs_writedata,
   input  logic                  avs_read,
   output logic [PORT_WIDTH-1:0] avs_readdata,
   output logic                  avs_waitrequest,
   output logic [SLOTS-1:0]      we_ram,
   output logic [DIMX*4-1:0]     set_ram,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STROBE
   } state_t;

   state_t state, state_nxt;

   logic [PTR_W-1:0]      ptr;
   logic                  err;

   logic                  wr_ctrl, wr_data;
   logic                  start, clr;
   logic                  load_slot;   // DATA word captured this edge
   logic                  strobe_end;  // strobe cycle finishing this edge
   logic                  data_err;    // DATA write with no load running
   logic                  last_slot;

   logic [SLOTS-1:0]      ptr_onehot;
   logic [PORT_WIDTH-1:0] slot_word;
   logic [PORT_WIDTH-1:0] status_word;

   assign wr_ctrl   = avs_write && (avs_address == 2'd0);
   assign wr_data   = avs_write && (avs_address == 2'd2);
   assign start     = wr_ctrl && avs_writedata[0];
   assign clr       = wr_ctrl && avs_writedata[1];
   assign last_slot = (ptr == PTR_W'(SLOTS - 1));

   assign avs_waitrequest = (state == STROBE);
   assign busy            = (state != IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle control strobes
   always_comb begin
      state_nxt  = state;
      load_slot  = 1'b0;
      strobe_end = 1'b0;
      data_err   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
            end else if (wr_data) begin
               data_err = 1'b1;
            end
         end
         LOAD: begin
            if (start) begin
               state_nxt = LOAD;
            end else if (wr_data) begin
               load_slot = 1'b1;
               state_nxt = STROBE;
            end
         end
         STROBE: begin
            // DATA writes are stalled here; START still restarts the load
            // once the strobe already on we_ram completes.
            strobe_end = 1'b1;
            if (start) begin
               state_nxt = LOAD;
            end else if (last_slot) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = LOAD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slot decode of the pointer: one-hot enable and the addressed word
   always_comb begin
      ptr_onehot = '0;
      slot_word  = '0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
         if (ptr == PTR_W'(k)) begin
            ptr_onehot[k] = 1'b1;
            slot_word     = set_ram[k*PORT_WIDTH +: PORT_WIDTH];
         end
      end
   end

   always_comb begin
      status_word             = '0;
      status_word[0]          = busy;
      status_word[1]          = done;
      status_word[2]          = err;
      status_word[8 +: PTR_W] = ptr;
   end

   // Datapath: slot data, strobe, pointer and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         we_ram  <= '0;
         set_ram <= '0;
         ptr     <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
      end else begin
         // Registered strobe: high for exactly the STROBE cycle
         we_ram <= load_slot ? ptr_onehot : '0;

         if (load_slot) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
               if (ptr == PTR_W'(k)) begin
                  set_ram[k*PORT_WIDTH +: PORT_WIDTH] <= avs_writedata;
               end
            end
         end

         if (start) begin
            ptr  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
         end else begin
            if (clr) begin
               done <= 1'b0;
               err  <= 1'b0;
            end
            if (data_err) begin
               err <= 1'b1;
            end
            if (strobe_end) begin
               if (last_slot) begin
                  ptr  <= '0;
                  done <= 1'b1;
               end else begin
                  ptr <= ptr + PTR_W'(1);
               end
            end
         end
      end
   end

   // Read port: a simultaneous write wins and readdata holds its value
   always_ff @(posedge clk) begin
      if (rst) begin
         avs_readdata <= '0;
      end else if (avs_read && !avs_write) begin
         case (avs_address)
            2'd1:    avs_readdata <= status_word;
            2'd2:    avs_readdata <= slot_word;
            default: avs_readdata <= '0;
         endcase
      end
   end

endmodule
